// File: rtl/data_memory_if.sv
// Load/store bus between the issue/retire side (master) and data_memory (slave).
// Signal names keep the legacy port names so existing hookups map one-to-one.
interface data_memory_if;
  logic        i_r_req;
  logic [31:0] i_r_mem_addr;
  logic        o_r_ready;
  logic        o_r_valid;
  logic [31:0] o_r_mem_data;
  logic        o_r_err;
  logic        i_w_en;
  logic [31:0] i_w_addr;
  logic [31:0] i_w_data;
  logic [3:0]  i_w_be;

  modport slave (
    input  i_r_req, i_r_mem_addr, i_w_en, i_w_addr, i_w_data, i_w_be,
    output o_r_ready, o_r_valid, o_r_mem_data, o_r_err
  );

  modport master (
    output i_r_req, i_r_mem_addr, i_w_en, i_w_addr, i_w_data, i_w_be,
    input  o_r_ready, o_r_valid, o_r_mem_data, o_r_err
  );
endinterface

// File: rtl/data_memory.sv
// Word-addressed data memory: fixed-latency load FSM plus byte-enabled stores.
// Define DATA_MEMORY_BYPASS_EN to forward a same-edge store into the load response.
module data_memory #(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 2
) (
  input logic         i_clk,
  input logic         i_rst_n,
  data_memory_if.slave bus
);
  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [1:0]  CNT_INIT = 2'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e        state_q;
  logic [1:0]    cnt_q;
  logic [AW+1:0] addr_q;
  logic          ready_q;
  logic          valid_q;
  logic          err_q;
  logic [31:0]   data_q;

  logic [31:0]   mem [DEPTH];

  logic          accept;
  logic          resp_entry;
  logic [AW+1:0] rd_addr;
  logic [AW-1:0] rd_idx;
  logic [AW-1:0] w_idx;
  logic [31:0]   rd_data_d;
  logic          rd_err_d;
  logic          unused_addr_bits;

  assign accept     = (state_q == IDLE) && ready_q && bus.i_r_req;
  assign resp_entry = (accept && (LATENCY == 1)) || ((state_q == WAIT) && (cnt_q == 2'd1));
  // With LATENCY=1 the array is read on the accepting edge, so use the live address.
  assign rd_addr    = accept ? bus.i_r_mem_addr[AW+1:0] : addr_q;
  assign rd_idx     = rd_addr[AW+1:2];
  assign w_idx      = bus.i_w_addr[AW+1:2];

  assign unused_addr_bits = ^{bus.i_r_mem_addr[31:AW+2], bus.i_w_addr[31:AW+2], bus.i_w_addr[1:0]};

  always_comb begin
    rd_data_d = mem[rd_idx];
`ifdef DATA_MEMORY_BYPASS_EN
    if (bus.i_w_en && (w_idx == rd_idx)) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (bus.i_w_be[b]) rd_data_d[8*b +: 8] = bus.i_w_data[8*b +: 8];
      end
    end
`endif
    rd_err_d = (rd_addr[1:0] != 2'b00);
    if (rd_err_d) rd_data_d = '0;
  end

  // Array is intentionally not reset; stores are simply gated by reset.
  always_ff @(posedge i_clk) begin
    if (i_rst_n && bus.i_w_en) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (bus.i_w_be[b]) mem[w_idx][8*b +: 8] <= bus.i_w_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= 1'b0;
      if (resp_entry) begin
        valid_q <= 1'b1;
        data_q  <= rd_data_d;
        err_q   <= rd_err_d;
      end
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            addr_q  <= bus.i_r_mem_addr[AW+1:0];
            ready_q <= 1'b0;
            if (LATENCY == 1) begin
              state_q <= RESP;
            end else begin
              state_q <= WAIT;
              cnt_q   <= CNT_INIT;
            end
          end else begin
            ready_q <= 1'b1;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - 2'd1;
          if (cnt_q == 2'd1) state_q <= RESP;
        end
        RESP: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.o_r_ready    = ready_q;
  assign bus.o_r_valid    = valid_q;
  assign bus.o_r_mem_data = data_q;
  assign bus.o_r_err      = err_q;
endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory (DEPTH=256, LATENCY=2): vector table plus
// hand sequences for back-to-back loads, same-edge store forwarding and mid-load reset.
module tb_data_memory;
  localparam int unsigned LAT = 2;

  logic clk;
  logic rst_n;
  int   vecs;
  int   miscompares;

  data_memory_if bus ();

  data_memory #(.DEPTH(256), .LATENCY(LAT)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          is_load;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (bus.o_r_ready !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check({name, " ready"}, {31'd0, bus.o_r_ready}, 32'd1);
  endtask

  task automatic do_store(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
    bus.i_w_en   = 1'b1;
    bus.i_w_addr = addr;
    bus.i_w_data = data;
    bus.i_w_be   = be;
    step();
    bus.i_w_en   = 1'b0;
  endtask

  task automatic do_load(input string name, input logic [31:0] addr,
                         input logic [31:0] exp_data, input logic exp_err);
    int cyc;
    wait_ready(name);
    bus.i_r_req      = 1'b1;
    bus.i_r_mem_addr = addr;
    step();
    bus.i_r_req = 1'b0;
    check({name, " ready_low"}, {31'd0, bus.o_r_ready}, 32'd0);
    cyc = 1;
    while (bus.o_r_valid !== 1'b1 && cyc < 20) begin
      step();
      cyc++;
    end
    check({name, " latency"}, cyc, LAT);
    check({name, " data"}, bus.o_r_mem_data, exp_data);
    check({name, " err"}, {31'd0, bus.o_r_err}, {31'd0, exp_err});
    step();
    check({name, " pulse"}, {31'd0, bus.o_r_valid}, 32'd0);
    check({name, " hold"}, bus.o_r_mem_data, exp_data);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vtab[$];
    logic [31:0] exp_byp;

    vecs = 0;
    miscompares = 0;
    rst_n = 1'b0;
    bus.i_r_req = 1'b0;
    bus.i_r_mem_addr = '0;
    bus.i_w_en = 1'b0;
    bus.i_w_addr = '0;
    bus.i_w_data = '0;
    bus.i_w_be = '0;

    vtab.push_back('{1'b0, 32'h10,       32'hDEADBEEF, 4'b1111, 32'h0,        1'b0});
    vtab.push_back('{1'b1, 32'h10,       32'h0,        4'b0000, 32'hDEADBEEF, 1'b0});
    vtab.push_back('{1'b0, 32'h20,       32'h11223344, 4'b1111, 32'h0,        1'b0});
    vtab.push_back('{1'b0, 32'h20,       32'hAABBCCDD, 4'b0101, 32'h0,        1'b0});
    vtab.push_back('{1'b1, 32'h20,       32'h0,        4'b0000, 32'h11BB33DD, 1'b0});
    vtab.push_back('{1'b1, 32'h22,       32'h0,        4'b0000, 32'h0,        1'b1});
    vtab.push_back('{1'b1, 32'h21,       32'h0,        4'b0000, 32'h0,        1'b1});
    vtab.push_back('{1'b0, 32'h0,        32'hCAFEF00D, 4'b1111, 32'h0,        1'b0});
    vtab.push_back('{1'b1, 32'h400,      32'h0,        4'b0000, 32'hCAFEF00D, 1'b0});
    vtab.push_back('{1'b0, 32'h13,       32'h12345678, 4'b1000, 32'h0,        1'b0});
    vtab.push_back('{1'b1, 32'h10,       32'h0,        4'b0000, 32'h12ADBEEF, 1'b0});
    vtab.push_back('{1'b0, 32'h14,       32'h01020304, 4'b1111, 32'h0,        1'b0});
    vtab.push_back('{1'b0, 32'h14,       32'hFFFFFFFF, 4'b0000, 32'h0,        1'b0});
    vtab.push_back('{1'b1, 32'h14,       32'h0,        4'b0000, 32'h01020304, 1'b0});
    vtab.push_back('{1'b0, 32'h3FC,      32'hA5A55A5A, 4'b1111, 32'h0,        1'b0});
    vtab.push_back('{1'b1, 32'hFFFFFFFC, 32'h0,        4'b0000, 32'hA5A55A5A, 1'b0});

    // Reset state
    step();
    step();
    check("rst ready", {31'd0, bus.o_r_ready}, 32'd0);
    check("rst valid", {31'd0, bus.o_r_valid}, 32'd0);
    check("rst err", {31'd0, bus.o_r_err}, 32'd0);
    check("rst data", bus.o_r_mem_data, 32'd0);
    rst_n = 1'b1;
    check("rel ready_before_edge", {31'd0, bus.o_r_ready}, 32'd0);
    step();
    check("rel ready_after_edge", {31'd0, bus.o_r_ready}, 32'd1);

    for (int i = 0; i < vtab.size(); i++) begin
      if (vtab[i].is_load)
        do_load($sformatf("v%0d", i), vtab[i].addr, vtab[i].exp_data, vtab[i].exp_err);
      else
        do_store(vtab[i].addr, vtab[i].data, vtab[i].be);
    end

    // Held request: accepted every third edge
    wait_ready("thru");
    bus.i_r_req = 1'b1;
    bus.i_r_mem_addr = 32'h10;
    for (int k = 1; k <= 9; k++) begin
      step();
      check($sformatf("thru k%0d ready", k), {31'd0, bus.o_r_ready}, (k % 3 == 0) ? 32'd1 : 32'd0);
      check($sformatf("thru k%0d valid", k), {31'd0, bus.o_r_valid}, (k % 3 == 2) ? 32'd1 : 32'd0);
      if (k % 3 == 2) check($sformatf("thru k%0d data", k), bus.o_r_mem_data, 32'h12ADBEEF);
    end
    bus.i_r_req = 1'b0;

    // Store to the captured word on the RESP-entry edge
    do_store(32'h30, 32'h1, 4'b1111);
    wait_ready("byp");
    bus.i_r_req = 1'b1;
    bus.i_r_mem_addr = 32'h30;
    step();
    bus.i_r_req = 1'b0;
    bus.i_w_en = 1'b1;
    bus.i_w_addr = 32'h30;
    bus.i_w_data = 32'h2;
    bus.i_w_be = 4'b1111;
    step();
    bus.i_w_en = 1'b0;
`ifdef DATA_MEMORY_BYPASS_EN
    exp_byp = 32'h2;
`else
    exp_byp = 32'h1;
`endif
    check("byp valid", {31'd0, bus.o_r_valid}, 32'd1);
    check("byp data", bus.o_r_mem_data, exp_byp);
    do_load("byp_next", 32'h30, 32'h2, 1'b0);

    // Reset during WAIT abandons the load; stores blocked during reset
    wait_ready("mrst");
    bus.i_r_req = 1'b1;
    bus.i_r_mem_addr = 32'h10;
    step();
    bus.i_r_req = 1'b0;
    check("mrst in_wait", {31'd0, bus.o_r_ready}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mrst ready", {31'd0, bus.o_r_ready}, 32'd0);
    check("mrst valid", {31'd0, bus.o_r_valid}, 32'd0);
    check("mrst err", {31'd0, bus.o_r_err}, 32'd0);
    check("mrst data", bus.o_r_mem_data, 32'd0);
    bus.i_w_en = 1'b1;
    bus.i_w_addr = 32'h20;
    bus.i_w_data = 32'hFFFFFFFF;
    bus.i_w_be = 4'b1111;
    step();
    step();
    bus.i_w_en = 1'b0;
    rst_n = 1'b1;
    check("mrst ready_before_edge", {31'd0, bus.o_r_ready}, 32'd0);
    step();
    check("mrst ready_after_edge", {31'd0, bus.o_r_ready}, 32'd1);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("mrst no_valid%0d", k), {31'd0, bus.o_r_valid}, 32'd0);
      step();
    end
    do_load("mrst_blocked", 32'h20, 32'h11BB33DD, 1'b0);
    do_load("mrst_kept", 32'h10, 32'h12ADBEEF, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end
endmodule
